// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer and flush
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
    parameter int DATA_W      = 160,
    parameter bit ZERO_ON_POP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        level,
    output logic [15:0]       stall_cnt
);

    // State bits are {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic pop;

    assign main_valid = state[1];
    assign skid_valid = state[0];

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign level     = {1'b0, main_valid} + {1'b0, skid_valid};

    assign accept = in_valid && in_ready;
    assign pop    = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        state     <= FULL;
                        main_data <= in_data;
                    end
                end
                FULL: begin
                    if (pop && accept) begin
                        main_data <= in_data;
                    end else if (pop) begin
                        state <= EMPTY;
                        if (ZERO_ON_POP) begin
                            main_data <= '0;
                        end
                    end else if (accept) begin
                        state     <= SKID;
                        skid_data <= in_data;
                    end
                end
                SKID: begin
                    if (pop) begin
                        state     <= FULL;
                        main_data <= skid_data;
                        skid_data <= '0;
                    end
                end
                default: begin
                    // Self-recover from the illegal encoding rather than lock up.
                    state     <= EMPTY;
                    main_data <= '0;
                    skid_data <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating; flush deliberately leaves it alone so stalls survive bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if (main_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    level;
    logic [15:0]   stall_cnt;

    logic [DW-1:0] exp_q[$];
    int            checks   = 0;
    int            failures = 0;

`ifdef PIPE_STALL_CNT_EN
    localparam logic [15:0] STALL5 = 16'd5;
`else
    localparam logic [15:0] STALL5 = 16'd0;
`endif

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .ZERO_ON_POP(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected-data producer: records every accept that will take effect.
    always @(negedge clk) begin
        if (reset || flush)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(in_data);
    end

    // Monitor: every pop must deliver the oldest outstanding item.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h required=none", out_data);
            end else begin
                chk("sb_order", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data",  {16'h0, out_data},  32'h0);
        chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
        chk("rst_level",     {30'h0, level},     32'h0);
        chk("rst_stall",     {16'h0, stall_cnt}, 32'h0);

        // 1: single item latency
        in_valid = 1'b1; in_data = 16'hA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_out_data",  {16'h0, out_data},  32'hA5);
        chk("t1_level",     {30'h0, level},     32'h1);
        chk("t1_in_ready",  {31'h0, in_ready},  32'h1);
        step();
        chk("t1_empty_valid", {31'h0, out_valid}, 32'h0);
        chk("t1_empty_data",  {16'h0, out_data},  32'h0);

        // 2: full-rate streaming
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
            chk("t2_data",     {16'h0, out_data}, 32'(i));
            chk("t2_level",    {30'h0, level},    32'h1);
            chk("t2_in_ready", {31'h0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        step();
        chk("t2_drained", {30'h0, level}, 32'h0);

        // 3: fill skid, then drain
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h10;
        step();
        in_data = 16'h11;
        step();
        in_valid = 1'b0;
        chk("t3_level",    {30'h0, level},    32'h2);
        chk("t3_in_ready", {31'h0, in_ready}, 32'h0);
        chk("t3_head",     {16'h0, out_data}, 32'h10);
        out_ready = 1'b1;
        step();
        chk("t3_second",   {16'h0, out_data}, 32'h11);
        chk("t3_level1",   {30'h0, level},    32'h1);
        step();
        chk("t3_empty_valid", {31'h0, out_valid}, 32'h0);
        chk("t3_empty_data",  {16'h0, out_data},  32'h0);

        // 4: flush from SKID drops everything including same-cycle accept
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h20;
        step();
        in_data = 16'h21;
        step();
        flush = 1'b1; in_data = 16'h22;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t4_out_data",  {16'h0, out_data},  32'h0);
        chk("t4_level",     {30'h0, level},     32'h0);
        chk("t4_in_ready",  {31'h0, in_ready},  32'h1);
        out_ready = 1'b1;
        step(); step();
        chk("t4_no_ghost", {31'h0, out_valid}, 32'h0);

        // 5: reset from SKID
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h30;
        step();
        in_data = 16'h31;
        step();
        chk("t5_skid_level", {30'h0, level}, 32'h2);
        reset = 1'b1; in_data = 16'h32; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("t5_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_out_data",  {16'h0, out_data},  32'h0);
        chk("t5_in_ready",  {31'h0, in_ready},  32'h1);
        chk("t5_level",     {30'h0, level},     32'h0);
        chk("t5_stall",     {16'h0, stall_cnt}, 32'h0);

        // 6: stall counting survives flush
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h40;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("t6_stall5", {16'h0, stall_cnt}, {16'h0, STALL5});
        chk("t6_head",   {16'h0, out_data},  32'h40);
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flushed",     {30'h0, level},     32'h0);
        chk("t6_stall_flush", {16'h0, stall_cnt}, {16'h0, STALL5});
        step(); step();
        chk("t6_stall_hold",  {16'h0, stall_cnt}, {16'h0, STALL5});
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
